// File: rtl/timer_sched_if.sv
// timer_sched_if: MMIO slot bus plus event port and interrupt of timer_sched.
// master drives the slot and the consumer ready; slave is the scheduler side.
interface timer_sched_if;
    logic        cs;
    logic        read;
    logic        write;
    logic [4:0]  addr;
    logic [31:0] wr_data;
    logic [31:0] rd_data;
    logic        evt_valid;
    logic [1:0]  evt_id;
    logic        evt_ready;
    logic        irq;

    modport master (
        output cs, read, write, addr, wr_data, evt_ready,
        input  rd_data, evt_valid, evt_id, irq
    );

    modport slave (
        input  cs, read, write, addr, wr_data, evt_ready,
        output rd_data, evt_valid, evt_id, irq
    );
endinterface

// File: rtl/timer_sched.sv
// timer_sched: four alarm channels, shared prescaler, round-robin event port.
// Define TIMER_SCHED_OVERRUN_EN to track per-channel overrun in STATUS[7:4].
module timer_sched #(
    parameter int W  = 32,
    parameter int PW = 16
) (
    input  logic         clk,
    input  logic         reset,
    timer_sched_if.slave bus
);
    localparam int NCH = 4;

    logic [W-1:0]   period_q [NCH];
    logic [W-1:0]   period_d [NCH];
    logic [W-1:0]   count_q  [NCH];
    logic [W-1:0]   count_d  [NCH];
    logic [NCH-1:0] en_q, en_d;
    logic [NCH-1:0] per_q, per_d;
    logic [NCH-1:0] expired_q, expired_d;
    logic [NCH-1:0] pend_q, pend_d;
    logic [3:0]     mask_q, mask_d;
    logic [PW-1:0]  presc_q, presc_d;
    logic [PW-1:0]  p_q, p_d;
    logic           evt_valid_q, evt_valid_d;
    logic [1:0]     evt_id_q, evt_id_d;
    logic [1:0]     last_q, last_d;
    logic           irq_q, irq_d;

    logic           tick;
    logic           wr_en;
    logic           hs;
    logic [1:0]     ch;
    logic [NCH-1:0] expire;
    logic [1:0]     pick;
    logic           pick_ok;
    logic [1:0]     idx;
    logic [31:0]    rd;

    assign wr_en = bus.cs && bus.write;
    assign ch    = bus.addr[3:2];
    assign tick  = (p_q == presc_q);
    assign hs    = evt_valid_q && bus.evt_ready;

    always_comb begin
        p_d     = tick ? '0 : p_q + PW'(1);
        presc_d = presc_q;
        mask_d  = mask_q;
        if (wr_en && bus.addr == 5'h12) begin
            presc_d = bus.wr_data[PW-1:0];
            p_d     = '0;
        end
        if (wr_en && bus.addr == 5'h11)
            mask_d = bus.wr_data[3:0];

        expire = '0;
        for (int c = 0; c < NCH; c++) begin
            period_d[c] = period_q[c];
            count_d[c]  = count_q[c];
            en_d[c]     = en_q[c];
            per_d[c]    = per_q[c];
            if (tick && en_q[c] && count_q[c] != '0) begin
                count_d[c] = count_q[c] - W'(1);
                if (count_q[c] == W'(1)) begin
                    expire[c] = 1'b1;
                    if (per_q[c])
                        count_d[c] = period_q[c];
                    else
                        en_d[c] = 1'b0;
                end
            end
            // A CTRL write overrides the channel's own expiry update.
            if (wr_en && !bus.addr[4] && ch == c[1:0]) begin
                if (bus.addr[1:0] == 2'b00)
                    period_d[c] = bus.wr_data[W-1:0];
                if (bus.addr[1:0] == 2'b01) begin
                    en_d[c]  = bus.wr_data[0];
                    per_d[c] = bus.wr_data[1];
                    if (bus.wr_data[2])
                        count_d[c] = period_q[c];
                end
            end
        end
    end

    always_comb begin
        expired_d = expired_q;
        if (wr_en && bus.addr == 5'h10)
            expired_d = expired_d & ~bus.wr_data[3:0];
        expired_d = expired_d | expire;

        pend_d = pend_q;
        if (hs)
            pend_d[evt_id_q] = 1'b0;
        pend_d = pend_d | expire;
    end

    // Walk from farthest to nearest so the channel after last_grant wins.
    always_comb begin
        pick    = '0;
        pick_ok = 1'b0;
        idx     = '0;
        for (int k = NCH; k >= 1; k--) begin
            idx = last_q + k[1:0];
            if (pend_q[idx]) begin
                pick    = idx;
                pick_ok = 1'b1;
            end
        end

        evt_valid_d = evt_valid_q;
        evt_id_d    = evt_id_q;
        last_d      = last_q;
        if (hs) begin
            evt_valid_d = 1'b0;
        end else if (!evt_valid_q && pick_ok) begin
            evt_valid_d = 1'b1;
            evt_id_d    = pick;
            last_d      = pick;
        end

        irq_d = |(expired_q & mask_q);
    end

`ifdef TIMER_SCHED_OVERRUN_EN
    logic [NCH-1:0] overrun_q, overrun_d;

    always_comb begin
        overrun_d = overrun_q;
        if (wr_en && bus.addr == 5'h10)
            overrun_d = overrun_d & ~bus.wr_data[7:4];
        overrun_d = overrun_d | (expire & pend_q);
    end

    always_ff @(posedge clk) begin
        if (reset)
            overrun_q <= '0;
        else
            overrun_q <= overrun_d;
    end
`else
    logic [NCH-1:0] overrun_q;
    assign overrun_q = '0;
`endif

    always_comb begin
        rd = '0;
        if (!bus.addr[4]) begin
            unique case (bus.addr[1:0])
                2'b00:   rd = 32'(period_q[ch]);
                2'b01:   rd = {30'd0, per_q[ch], en_q[ch]};
                2'b10:   rd = 32'(count_q[ch]);
                default: rd = '0;
            endcase
        end else begin
            unique case (bus.addr[3:0])
                4'h0:    rd = {24'd0, overrun_q, expired_q};
                4'h1:    rd = {28'd0, mask_q};
                4'h2:    rd = 32'(presc_q);
                default: rd = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < NCH; c++) begin
                period_q[c] <= '0;
                count_q[c]  <= '0;
            end
            en_q        <= '0;
            per_q       <= '0;
            expired_q   <= '0;
            pend_q      <= '0;
            mask_q      <= '0;
            presc_q     <= '0;
            p_q         <= '0;
            evt_valid_q <= 1'b0;
            evt_id_q    <= '0;
            last_q      <= 2'd3;
            irq_q       <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                period_q[c] <= period_d[c];
                count_q[c]  <= count_d[c];
            end
            en_q        <= en_d;
            per_q       <= per_d;
            expired_q   <= expired_d;
            pend_q      <= pend_d;
            mask_q      <= mask_d;
            presc_q     <= presc_d;
            p_q         <= p_d;
            evt_valid_q <= evt_valid_d;
            evt_id_q    <= evt_id_d;
            last_q      <= last_d;
            irq_q       <= irq_d;
        end
    end

    assign bus.rd_data   = rd;
    assign bus.evt_valid = evt_valid_q;
    assign bus.evt_id    = evt_id_q;
    assign bus.irq       = irq_q;
endmodule

// File: tb/tb_timer_sched.sv
// tb_timer_sched: directed checks of timer_sched registers, expiry and arbiter.
// Expected values are hand-derived from the register and timing rules.
module tb_timer_sched;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ids[$];
    int   cys[$];

    timer_sched_if bus();

    timer_sched #(.W(32), .PW(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        bus.cs = 1'b1;
        bus.write = 1'b1;
        bus.addr = a;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.cs = 1'b0;
        bus.write = 1'b0;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] d);
        bus.addr = a;
        #1;
        d = bus.rd_data;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n, output logic ok);
        ok = 1'b0;
        n = 0;
        while (!ok && n < max) begin
            @(posedge clk);
            #1;
            n++;
            if (bus.evt_valid) ok = 1'b1;
        end
    endtask

    task automatic consume();
        bus.evt_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.evt_ready = 1'b0;
    endtask

    task automatic fire(input logic [3:0] m);
        ids.delete();
        cys.delete();
        wr(5'h12, 32'd15);
        for (int c = 0; c < 4; c++)
            if (m[c]) wr(5'(c * 4), 32'd1);
        for (int c = 0; c < 4; c++)
            if (m[c]) wr(5'(c * 4 + 1), 32'd5);
        bus.evt_ready = 1'b1;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (bus.evt_valid) begin
                ids.push_back(int'(bus.evt_id));
                cys.push_back(cyc);
            end
        end
        bus.evt_ready = 1'b0;
    endtask

    logic [31:0] v;
    int          n;
    logic        ok;
    logic        seen;

    initial begin
        bus.cs = 1'b0;
        bus.read = 1'b0;
        bus.write = 1'b0;
        bus.addr = '0;
        bus.wr_data = '0;
        bus.evt_ready = 1'b0;

        do_reset();
        chk("rst_valid", 32'(bus.evt_valid), 32'd0);
        chk("rst_id", 32'(bus.evt_id), 32'd0);
        chk("rst_irq", 32'(bus.irq), 32'd0);
        rd(5'h00, v); chk("rst_period0", v, 32'd0);
        rd(5'h01, v); chk("rst_ctrl0", v, 32'd0);
        rd(5'h10, v); chk("rst_status", v, 32'd0);
        rd(5'h12, v); chk("rst_presc", v, 32'd0);

        // One-shot expiry five cycles after load.
        wr(5'h12, 32'd0);
        wr(5'h00, 32'd5);
        rd(5'h00, v); chk("t1_period", v, 32'd5);
        wr(5'h01, 32'h5);
        rd(5'h02, v); chk("t1_count_load", v, 32'd5);
        repeat (5) @(posedge clk);
        #1;
        chk("t1_valid_at_expiry", 32'(bus.evt_valid), 32'd0);
        rd(5'h02, v); chk("t1_count_zero", v, 32'd0);
        rd(5'h10, v); chk("t1_status", v, 32'h1);
        @(posedge clk);
        #1;
        chk("t1_valid", 32'(bus.evt_valid), 32'd1);
        chk("t1_id", 32'(bus.evt_id), 32'd0);
        chk("t1_irq_masked", 32'(bus.irq), 32'd0);
        rd(5'h01, v); chk("t1_ctrl_en_off", v, 32'd0);
        consume();
        chk("t1_valid_drop", 32'(bus.evt_valid), 32'd0);

        // Periodic channel 1 through the prescaler, irq and STATUS clear.
        do_reset();
        wr(5'h11, 32'h2);
        wr(5'h12, 32'd3);
        wr(5'h04, 32'd2);
        wr(5'h05, 32'h7);
        chk("t2_irq_before", 32'(bus.irq), 32'd0);
        wait_valid(30, n, ok);
        chk("t2_first_ok", 32'(ok), 32'd1);
        chk("t2_first_lat", n, 32'd7);
        chk("t2_irq", 32'(bus.irq), 32'd1);
        chk("t2_id", 32'(bus.evt_id), 32'd1);
        consume();
        wait_valid(30, n, ok);
        chk("t2_second_ok", 32'(ok), 32'd1);
        chk("t2_period", n, 32'd7);
        wr(5'h10, 32'h2);
        @(posedge clk);
        #1;
        chk("t2_irq_cleared", 32'(bus.irq), 32'd0);
        rd(5'h10, v); chk("t2_status_cleared", v, 32'd0);
        chk("t2_pend_kept", 32'(bus.evt_valid), 32'd1);

        // Round-robin order across three rounds.
        do_reset();
        fire(4'b1101);
        chk("t3_r1_n", ids.size(), 32'd3);
        if (ids.size() == 3) begin
            chk("t3_r1_id0", ids[0], 32'd0);
            chk("t3_r1_id1", ids[1], 32'd2);
            chk("t3_r1_id2", ids[2], 32'd3);
            chk("t3_r1_gap1", cys[1] - cys[0], 32'd2);
            chk("t3_r1_gap2", cys[2] - cys[1], 32'd2);
        end
        fire(4'b0011);
        chk("t3_r2_n", ids.size(), 32'd2);
        if (ids.size() == 2) begin
            chk("t3_r2_id0", ids[0], 32'd0);
            chk("t3_r2_id1", ids[1], 32'd1);
        end
        fire(4'b0101);
        chk("t3_r3_n", ids.size(), 32'd2);
        if (ids.size() == 2) begin
            chk("t3_r3_id0", ids[0], 32'd2);
            chk("t3_r3_id1", ids[1], 32'd0);
        end

        // Held event across a second expiry of channel 0.
        do_reset();
        wr(5'h12, 32'd0);
        wr(5'h00, 32'd3);
        wr(5'h01, 32'h7);
        wait_valid(20, n, ok);
        chk("t4_ok", 32'(ok), 32'd1);
        chk("t4_lat", n, 32'd4);
        repeat (3) @(posedge clk);
        #1;
        chk("t4_held_valid", 32'(bus.evt_valid), 32'd1);
        chk("t4_held_id", 32'(bus.evt_id), 32'd0);
        rd(5'h10, v);
`ifdef TIMER_SCHED_OVERRUN_EN
        chk("t4_status_ovr", v, 32'h11);
`else
        chk("t4_status_ovr", v, 32'h01);
`endif
        wr(5'h01, 32'h0);
        consume();
        chk("t4_drop", 32'(bus.evt_valid), 32'd0);
        seen = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            if (bus.evt_valid) seen = 1'b1;
        end
        chk("t4_single_event", 32'(seen), 32'd0);

        // PERIOD=0 stays idle; then reset while an event is held.
        do_reset();
        wr(5'h12, 32'd0);
        wr(5'h01, 32'h7);
        seen = 1'b0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (bus.evt_valid) seen = 1'b1;
        end
        chk("t5_idle", 32'(seen), 32'd0);
        rd(5'h10, v); chk("t5_idle_status", v, 32'd0);
        wr(5'h11, 32'h1);
        wr(5'h00, 32'd2);
        wr(5'h01, 32'h5);
        wait_valid(10, n, ok);
        chk("t5_ok", 32'(ok), 32'd1);
        chk("t5_irq_pre", 32'(bus.irq), 32'd1);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("t5_rst_valid", 32'(bus.evt_valid), 32'd0);
        chk("t5_rst_id", 32'(bus.evt_id), 32'd0);
        chk("t5_rst_irq", 32'(bus.irq), 32'd0);
        rd(5'h00, v); chk("t5_rst_period", v, 32'd0);
        rd(5'h10, v); chk("t5_rst_status", v, 32'd0);
        rd(5'h11, v); chk("t5_rst_mask", v, 32'd0);
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk);
            #1;
            if (bus.evt_valid) seen = 1'b1;
        end
        chk("t5_pend_discarded", 32'(seen), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
